// File: rtl/io_host_port.sv
// io_host_port: host-side peer of the processor's memory-mapped I/O pins.
// One FIFO carries host words to read_in, the other returns write_out words to the host.
module io_host_port #(
  parameter int WIDTH = 16,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4,
  parameter logic [WIDTH-1:0] EMPTY_WORD = 16'h0000
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [WIDTH-1:0] read_in,
  input  logic             cpu_read_ack,
  input  logic [WIDTH-1:0] write_out,
  input  logic             cpu_write_strobe,
  output logic             in_avail,
  output logic             out_full,
  output logic             overflow_err,
  output logic             underflow_err
);
  localparam int IA = $clog2(IN_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
  localparam logic [IA:0] IN_FULL = (IA+1)'(IN_DEPTH);
  localparam logic [OA:0] OUT_FULL = (OA+1)'(OUT_DEPTH);

  logic [WIDTH-1:0] in_mem_q [IN_DEPTH];
  logic [WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [IA:0] in_cnt_q, in_cnt_d;
  logic [IA-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [OA:0] out_cnt_q, out_cnt_d;
  logic [OA-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic in_push, in_pop, out_push, out_pop;

  assign host_in_ready = in_cnt_q != IN_FULL;
  assign in_avail = in_cnt_q != '0;
  assign read_in = in_avail ? in_mem_q[in_rp_q] : EMPTY_WORD;
  assign host_out_valid = out_cnt_q != '0;
  assign out_full = out_cnt_q == OUT_FULL;
  assign host_out_data = host_out_valid ? out_mem_q[out_rp_q] : '0;
  assign overflow_err = ovf_q;
  assign underflow_err = unf_q;

  // Full-ness is judged on the pre-edge count, so a same-cycle pop never admits a push.
  always_comb begin
    in_push = host_in_valid && host_in_ready;
    in_pop = cpu_read_ack && in_avail;
    out_push = cpu_write_strobe && !out_full;
    out_pop = host_out_valid && host_out_ready;
    in_cnt_d = in_cnt_q + (IA+1)'(in_push) - (IA+1)'(in_pop);
    in_wp_d = in_wp_q + IA'(in_push);
    in_rp_d = in_rp_q + IA'(in_pop);
    out_cnt_d = out_cnt_q + (OA+1)'(out_push) - (OA+1)'(out_pop);
    out_wp_d = out_wp_q + OA'(out_push);
    out_rp_d = out_rp_q + OA'(out_pop);
    ovf_d = ovf_q || (cpu_write_strobe && out_full);
    unf_d = unf_q || (cpu_read_ack && !in_avail);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q <= '0;
      in_wp_q <= '0;
      in_rp_q <= '0;
      out_cnt_q <= '0;
      out_wp_q <= '0;
      out_rp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      in_wp_q <= in_wp_d;
      in_rp_q <= in_rp_d;
      out_cnt_q <= out_cnt_d;
      out_wp_q <= out_wp_d;
      out_rp_q <= out_rp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage needs no reset: outputs are gated by the counts.
  always_ff @(posedge clock) begin
    if (in_push) in_mem_q[in_wp_q] <= host_in_data;
    if (out_push) out_mem_q[out_wp_q] <= write_out;
  end
endmodule

// File: tb/tb_io_host_port.sv
// tb_io_host_port: queue-based reference model plus decoupled scoreboard monitor for io_host_port.
module tb_io_host_port;
  localparam int ID = 4;
  localparam int OD = 4;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] host_in_data = '0, host_out_data, read_in, write_out = '0;
  logic host_in_valid = 1'b0, host_in_ready, host_out_valid, host_out_ready = 1'b0;
  logic cpu_read_ack = 1'b0, cpu_write_strobe = 1'b0;
  logic in_avail, out_full, overflow_err, underflow_err;
  int tests = 0, fails = 0;
  logic [15:0] mdl_in[$], mdl_out[$], exp_in[$], exp_out[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;

  io_host_port dut (
    .clock(clock), .rst_n(rst_n),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .read_in(read_in), .cpu_read_ack(cpu_read_ack),
    .write_out(write_out), .cpu_write_strobe(cpu_write_strobe),
    .in_avail(in_avail), .out_full(out_full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " in_ready"}, 32'(host_in_ready), 32'(mdl_in.size() != ID));
    chk({tag, " in_avail"}, 32'(in_avail), 32'(mdl_in.size() != 0));
    chk({tag, " read_in"}, 32'(read_in), mdl_in.size() != 0 ? 32'(mdl_in[0]) : 32'h0);
    chk({tag, " out_valid"}, 32'(host_out_valid), 32'(mdl_out.size() != 0));
    chk({tag, " out_full"}, 32'(out_full), 32'(mdl_out.size() == OD));
    chk({tag, " out_data"}, 32'(host_out_data), mdl_out.size() != 0 ? 32'(mdl_out[0]) : 32'h0);
    chk({tag, " overflow"}, 32'(overflow_err), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow_err), 32'(m_unf));
  endtask

  // Called at posedge+1: drives one cycle of inputs, applies the FIFO rules to the model, checks after the edge.
  task automatic cycle(input logic hv, input logic [15:0] hd, input logic ack,
                       input logic ws, input logic [15:0] wd, input logic hr, input string tag);
    logic in_ok, in_pop, out_ok, out_pop;
    host_in_valid = hv; host_in_data = hd; cpu_read_ack = ack;
    cpu_write_strobe = ws; write_out = wd; host_out_ready = hr;
    in_ok = hv && mdl_in.size() < ID;
    in_pop = ack && mdl_in.size() != 0;
    out_ok = ws && mdl_out.size() < OD;
    out_pop = hr && mdl_out.size() != 0;
    if (ack && mdl_in.size() == 0) m_unf = 1'b1;
    if (ws && mdl_out.size() == OD) m_ovf = 1'b1;
    @(posedge clock); #1;
    if (in_pop) void'(mdl_in.pop_front());
    if (in_ok) begin mdl_in.push_back(hd); exp_in.push_back(hd); end
    if (out_pop) void'(mdl_out.pop_front());
    if (out_ok) begin mdl_out.push_back(wd); exp_out.push_back(wd); end
    check_state(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, tag);
  endtask

  task automatic clear_model();
    mdl_in.delete(); mdl_out.delete(); exp_in.delete(); exp_out.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word that is about to be consumed.
  initial begin
    logic hold = 1'b0;
    logic [15:0] hold_data = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) hold = 1'b0;
      else begin
        if (cpu_read_ack && in_avail) begin
          if (exp_in.size() == 0) chk("sb_in unexpected word", 32'(read_in), 32'hxxxx_xxxx);
          else chk("sb_in", 32'(read_in), 32'(exp_in.pop_front()));
        end
        if (host_out_valid && host_out_ready) begin
          if (exp_out.size() == 0) chk("sb_out unexpected word", 32'(host_out_data), 32'hxxxx_xxxx);
          else chk("sb_out", 32'(host_out_data), 32'(exp_out.pop_front()));
        end
        if (hold) chk("sb_out hold stable", 32'(host_out_data), 32'(hold_data));
        hold = host_out_valid && !host_out_ready;
        hold_data = host_out_data;
      end
    end
  end

  initial begin
    // T1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      host_in_valid = 1'($urandom); host_in_data = 16'($urandom); cpu_read_ack = 1'($urandom);
      cpu_write_strobe = 1'($urandom); write_out = 16'($urandom); host_out_ready = 1'($urandom);
      @(posedge clock); #1;
      check_state("T1");
    end
    host_in_valid = 0; cpu_read_ack = 0; cpu_write_strobe = 0; host_out_ready = 0;
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    // T2: in-order host->cpu
    cycle(1, 16'h1111, 0, 0, 0, 0, "T2");
    cycle(1, 16'h2222, 0, 0, 0, 0, "T2");
    cycle(1, 16'h3333, 0, 0, 0, 0, "T2");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, "T2");
    // T3: full host->cpu refuses BEEF even with a concurrent ack
    for (int i = 0; i < 4; i++) cycle(1, 16'h4000 + 16'(i), 0, 0, 0, 0, "T3");
    cycle(1, 16'hBEEF, 1, 0, 0, 0, "T3");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, "T3");
    // T4: overflow of cpu->host, then drain
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 16'hA000 + 16'(i), 0, "T4");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1, "T4");
    // T5: backpressure, then strobe+pop at count 2
    cycle(0, 0, 0, 1, 16'hB000, 0, "T5");
    cycle(0, 0, 0, 1, 16'hB001, 0, "T5");
    idle(3, "T5");
    cycle(0, 0, 0, 1, 16'hB002, 1, "T5");
    cycle(0, 0, 0, 0, 0, 1, "T5");
    cycle(0, 0, 0, 0, 0, 1, "T5");
    // T6: underflow
    cycle(0, 0, 1, 0, 0, 0, "T6");
    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 3) == 0), "RND");
    cycle(1, 16'h5555, 0, 1, 16'h6666, 0, "T6");
    // T6: asynchronous reset mid-stream, checked before any clock edge
    @(negedge clock); #2;
    rst_n = 1'b0; #1;
    clear_model();
    check_state("T6 async");
    host_in_valid = 0; cpu_read_ack = 0; cpu_write_strobe = 0; host_out_ready = 0;
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    check_state("T6 post");
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), "RND2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
